spi_flash_slave: RTL and testbench

Byte-parallel SPI NOR-flash target that sits directly downstream of the APB-to-SPI controller and terminates its s_mosi/s_miso/s_clk/s_css bus. It decodes the command byte, a 24-bit address and the data phase. It serves write (0x02) and read (0x01) frames from an internal byte array. It is synthesizable and runs on the system clock, oversampling s_clk/s_css. It serves as both the flash stand-in for system simulation and an FPGA-side flash emulator.

---
 rtl/spi_flash_slave_pkg.sv | 19 +
 rtl/spi_edge_sync.sv | 26 ++
 rtl/spi_flash_slave.sv | 130 +++++++++++++
 tb/tb_spi_flash_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_slave_pkg.sv
// Shared constants and state encoding for the SPI NOR-flash target.
package spi_flash_slave_pkg;

    localparam int SPIBITWIDE = 8;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] MISO_IDLE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for an asynchronous control pin, plus a third flop
// so the caller can see the synchronised level and a one-cycle change strobe.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic p_clk,
    input  logic p_reset,
    input  logic sig_in,
    output logic level,
    output logic toggle
);

    logic [2:0] sync_q;

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
        end
    end

    assign level  = sync_q[1];
    assign toggle = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/spi_flash_slave.sv
// Byte-parallel SPI NOR-flash target: command, 24-bit address, then
// streaming write or read data against an internal byte array.
//
// state     | meaning
// ST_IDLE   | deselected, waiting for chip-select fall
// ST_CMD    | next s_clk rise carries the command byte
// ST_ADDR   | three s_clk rises carry address bytes, MSB first
// ST_WDATA  | each s_clk rise writes one byte, address post-increments
// ST_RDATA  | each s_clk rise advances the address and preloads s_miso
// ST_IGNORE | unknown command, clocks ignored until deselect
module spi_flash_slave #(
    parameter int DEPTH      = 256,
    parameter int SPIBITWIDE = spi_flash_slave_pkg::SPIBITWIDE
) (
    input  logic                  p_clk,
    input  logic                  p_reset,
    input  logic                  s_clk,
    input  logic                  s_css,
    input  logic [SPIBITWIDE-1:0] s_mosi,
    output logic [SPIBITWIDE-1:0] s_miso,
    output logic                  frame_done,
    output logic                  cmd_err
);

    import spi_flash_slave_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t state, state_nxt;
    logic        mode_rd;
    logic [23:0] addr;
    logic [1:0]  byte_cnt;

    logic clk_lvl, clk_tgl, css_lvl, css_tgl;
    logic clk_rise, css_rise, css_fall, rx;
    logic cmd_ok;
    logic [23:0] addr_shift, addr_inc;

    logic [SPIBITWIDE-1:0] mem [0:DEPTH-1] = '{default: '1};

    spi_edge_sync #(.RST_VAL(1'b0)) u_sync_clk (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .sig_in  (s_clk),
        .level   (clk_lvl),
        .toggle  (clk_tgl)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sync_css (
        .p_clk   (p_clk),
        .p_reset (p_reset),
        .sig_in  (s_css),
        .level   (css_lvl),
        .toggle  (css_tgl)
    );

    assign clk_rise = clk_tgl & clk_lvl;
    assign css_rise = css_tgl & css_lvl;
    assign css_fall = css_tgl & ~css_lvl;
    // A deselect in the same cycle as a clock rise swallows that byte.
    assign rx       = clk_rise & ~css_rise;

    assign cmd_ok     = (s_mosi == CMD_READ) || (s_mosi == CMD_WRITE);
    assign addr_shift = {addr[15:0], s_mosi};
    assign addr_inc   = addr + 24'd1;

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE) begin
            if (css_fall) state_nxt = ST_CMD;
        end else if (css_rise) begin
            state_nxt = ST_IDLE;
        end else if (rx) begin
            case (state)
                ST_CMD:  state_nxt = cmd_ok ? ST_ADDR : ST_IGNORE;
                ST_ADDR: if (byte_cnt == 2'd2) state_nxt = mode_rd ? ST_RDATA : ST_WDATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            s_miso     <= MISO_IDLE;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            mode_rd    <= 1'b0;
            addr       <= 24'd0;
            byte_cnt   <= 2'd0;
        end else begin
            frame_done <= (state != ST_IDLE) && css_rise;
            cmd_err    <= (state == ST_CMD) && rx && !cmd_ok;
            if (state != ST_IDLE && css_rise) begin
                s_miso <= MISO_IDLE;
            end else if (rx) begin
                case (state)
                    ST_CMD: begin
                        mode_rd  <= (s_mosi == CMD_READ);
                        byte_cnt <= 2'd0;
                    end
                    ST_ADDR: begin
                        addr     <= addr_shift;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2 && mode_rd) s_miso <= mem[addr_shift[AW-1:0]];
                    end
                    ST_WDATA: addr <= addr_inc;
                    ST_RDATA: begin
                        addr   <= addr_inc;
                        s_miso <= mem[addr_inc[AW-1:0]];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Array has no reset so completed writes survive p_reset.
    always_ff @(posedge p_clk) begin
        if (state == ST_WDATA && rx) mem[addr[AW-1:0]] <= s_mosi;
    end

endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave: write, read, wrap, bad command, abort,
// deselect racing a clock rise, and reset mid-frame.
module tb_spi_flash_slave;

    logic       p_clk   = 1'b0;
    logic       p_reset = 1'b0;
    logic       s_clk   = 1'b0;
    logic       s_css   = 1'b1;
    logic [7:0] s_mosi  = 8'h00;
    logic [7:0] s_miso;
    logic       frame_done;
    logic       cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int ce_cnt   = 0;

    always #5 p_clk = ~p_clk;

    spi_flash_slave #(.DEPTH(256), .SPIBITWIDE(8)) dut (
        .p_clk      (p_clk),
        .p_reset    (p_reset),
        .s_clk      (s_clk),
        .s_css      (s_css),
        .s_mosi     (s_mosi),
        .s_miso     (s_miso),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always @(negedge p_clk) begin
        if (frame_done) fd_cnt++;
        if (cmd_err) ce_cnt++;
    end

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] smp);
        s_mosi = b;
        @(negedge p_clk);
        smp = s_miso;
        s_clk = 1'b1;
        repeat (4) @(negedge p_clk);
        s_clk = 1'b0;
        repeat (4) @(negedge p_clk);
    endtask

    task automatic css_low();
        s_css = 1'b0;
        repeat (4) @(negedge p_clk);
    endtask

    task automatic css_high();
        s_css = 1'b1;
        repeat (6) @(negedge p_clk);
    endtask

    task automatic frame_start(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] smp;
        css_low();
        spi_byte(cmd, smp);
        spi_byte(a[23:16], smp);
        spi_byte(a[15:8], smp);
        spi_byte(a[7:0], smp);
    endtask

    task automatic test_reset();
        p_reset = 1'b1;
        repeat (3) @(negedge p_clk);
        p_reset = 1'b0;
        repeat (2) @(negedge p_clk);
        n_checks++;
        if (s_miso !== 8'hFF) begin n_fail++; $display("FAIL reset_miso: got %h expected ff", s_miso); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++;
        if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
    endtask

    task automatic test_write();
        logic [7:0] smp;
        logic [7:0] dat [4];
        int fd0, ce0;
        dat = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        fd0 = fd_cnt;
        ce0 = ce_cnt;
        frame_start(8'h02, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            spi_byte(dat[i], smp);
            n_checks++;
            if (smp !== 8'hFF) begin n_fail++; $display("FAIL write_miso[%0d]: got %h expected ff", i, smp); end
        end
        css_high();
        n_checks++;
        if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL write_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
        n_checks++;
        if (ce_cnt - ce0 !== 0) begin n_fail++; $display("FAIL write_cmd_err: got %0d pulses expected 0", ce_cnt - ce0); end
    endtask

    task automatic test_read();
        logic [7:0] smp;
        logic [7:0] exp [4];
        int fd0;
        exp = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        fd0 = fd_cnt;
        frame_start(8'h01, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, smp);
            n_checks++;
            if (smp !== exp[i]) begin n_fail++; $display("FAIL read_data[%0d]: got %h expected %h", i, smp, exp[i]); end
        end
        css_high();
        n_checks++;
        if (s_miso !== 8'hFF) begin n_fail++; $display("FAIL read_miso_idle: got %h expected ff", s_miso); end
        n_checks++;
        if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL read_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
    endtask

    task automatic test_wrap();
        logic [7:0] smp;
        logic [7:0] dat [4];
        dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        frame_start(8'h02, 24'h0000FE);
        for (int i = 0; i < 4; i++) spi_byte(dat[i], smp);
        css_high();
        frame_start(8'h01, 24'h0000FE);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, smp);
            n_checks++;
            if (smp !== dat[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, smp, dat[i]); end
        end
        css_high();
    endtask

    task automatic test_bad_cmd();
        logic [7:0] smp;
        logic [7:0] bytes [5];
        int fd0, ce0;
        bytes = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'hAA};
        fd0 = fd_cnt;
        ce0 = ce_cnt;
        css_low();
        for (int i = 0; i < 5; i++) begin
            spi_byte(bytes[i], smp);
            n_checks++;
            if (smp !== 8'hFF) begin n_fail++; $display("FAIL badcmd_miso[%0d]: got %h expected ff", i, smp); end
        end
        css_high();
        n_checks++;
        if (ce_cnt - ce0 !== 1) begin n_fail++; $display("FAIL badcmd_cmd_err: got %0d pulses expected 1", ce_cnt - ce0); end
        n_checks++;
        if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL badcmd_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
        frame_start(8'h01, 24'h000000);
        spi_byte(8'h00, smp);
        n_checks++;
        if (smp !== 8'h33) begin n_fail++; $display("FAIL badcmd_mem0: got %h expected 33", smp); end
        css_high();
    endtask

    task automatic test_abort();
        logic [7:0] smp;
        int fd0;
        fd0 = fd_cnt;
        css_low();
        spi_byte(8'h02, smp);
        spi_byte(8'h00, smp);
        spi_byte(8'h00, smp);
        css_high();
        n_checks++;
        if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL abort_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
        frame_start(8'h01, 24'h000000);
        spi_byte(8'h00, smp);
        n_checks++;
        if (smp !== 8'h33) begin n_fail++; $display("FAIL abort_next_mem0: got %h expected 33", smp); end
        spi_byte(8'h00, smp);
        n_checks++;
        if (smp !== 8'h44) begin n_fail++; $display("FAIL abort_next_mem1: got %h expected 44", smp); end
        css_high();
    endtask

    task automatic test_css_wins();
        logic [7:0] smp;
        int fd0;
        frame_start(8'h02, 24'h000020);
        spi_byte(8'h77, smp);
        fd0 = fd_cnt;
        s_mosi = 8'h99;
        @(negedge p_clk);
        s_clk = 1'b1;
        s_css = 1'b1;
        repeat (6) @(negedge p_clk);
        s_clk = 1'b0;
        repeat (4) @(negedge p_clk);
        n_checks++;
        if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL csswin_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
        frame_start(8'h01, 24'h000020);
        spi_byte(8'h00, smp);
        n_checks++;
        if (smp !== 8'h77) begin n_fail++; $display("FAIL csswin_mem20: got %h expected 77", smp); end
        spi_byte(8'h00, smp);
        n_checks++;
        if (smp !== 8'hFF) begin n_fail++; $display("FAIL csswin_mem21: got %h expected ff", smp); end
        css_high();
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] smp;
        int fd0;
        frame_start(8'h02, 24'h000010);
        spi_byte(8'h5A, smp);
        spi_byte(8'hA5, smp);
        fd0 = fd_cnt;
        p_reset = 1'b1;
        @(negedge p_clk);
        s_css = 1'b1;
        n_checks++;
        if (s_miso !== 8'hFF) begin n_fail++; $display("FAIL rstmid_miso: got %h expected ff", s_miso); end
        @(negedge p_clk);
        p_reset = 1'b0;
        repeat (6) @(negedge p_clk);
        n_checks++;
        if (fd_cnt - fd0 !== 0) begin n_fail++; $display("FAIL rstmid_frame_done: got %0d pulses expected 0", fd_cnt - fd0); end
        frame_start(8'h01, 24'h000010);
        spi_byte(8'h00, smp);
        n_checks++;
        if (smp !== 8'h5A) begin n_fail++; $display("FAIL rstmid_mem10: got %h expected 5a", smp); end
        spi_byte(8'h00, smp);
        n_checks++;
        if (smp !== 8'hA5) begin n_fail++; $display("FAIL rstmid_mem11: got %h expected a5", smp); end
        css_high();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_bad_cmd();
        test_abort();
        test_css_wins();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
